// File: rtl/usb_link_supervisor.sv
// usb_link_supervisor: brings up the USB init stage after reset, supervises
// the link while up, handles host suspend, and gives up after repeated
// ready timeouts until software requests a retry.
// Optional feature macro: USB_SUP_DROP_CNT_EN adds a saturating counter of
// UP->RESTART drops on link_drop_cnt. Without it the port is tied to zero.
module usb_link_supervisor #(
  parameter int WAKE_PULSE_CYCLES = 16,
  parameter int READY_TIMEOUT     = 1048576,
  parameter int MAX_RETRIES       = 3,
  parameter int LOCK_FILTER       = 8
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        usb_clk_lock,
  input  logic        n_ready,
  input  logic        suspend,
  input  logic        retry_req,
  output logic        wakeup,
  output logic        init_rst,
  output logic        link_up,
  output logic        fault,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  state,
  output logic [15:0] link_drop_cnt
);

  typedef enum logic [2:0] {
    ST_RESTART    = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_UP         = 3'd2,
    ST_SUSPEND    = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  localparam int LF_W = $clog2(LOCK_FILTER + 1);
  localparam logic [19:0]     WAKE_LAST     = 20'(WAKE_PULSE_CYCLES - 1);
  localparam logic [19:0]     READY_LAST    = 20'(READY_TIMEOUT - 1);
  localparam logic [1:0]      MAX_RETRY_CNT = 2'(MAX_RETRIES);
  localparam logic [LF_W-1:0] LF_MAX        = LF_W'(LOCK_FILTER);
  localparam logic [LF_W-1:0] LF_ONE        = LF_W'(1);

  state_t          state_q, state_d;
  logic [19:0]     timer_q, timer_d;
  logic [1:0]      retry_q, retry_d;
  logic [LF_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]      lock_sync_q, nrdy_sync_q, susp_sync_q;
  logic            init_rst_q, init_rst_d;
  logic            wakeup_q, wakeup_d;
  logic            link_up_q, link_up_d;
  logic            fault_q, fault_d;
  logic            lock_s, nrdy_s, susp_s;
  logic            lock_loss_s;
  logic            drop_inc_s;
  logic [1:0]      retry_inc_s;

  assign lock_s      = lock_sync_q[1];
  assign nrdy_s      = nrdy_sync_q[1];
  assign susp_s      = susp_sync_q[1];
  assign lock_loss_s = (lock_cnt_q == LF_MAX);
  assign retry_inc_s = retry_q + 2'd1;

  // Next-state, timer, retry and lock-filter logic; outputs follow the next state
  always_comb begin
    state_d    = state_q;
    timer_d    = 20'd0;
    retry_d    = retry_q;
    drop_inc_s = 1'b0;

    if (lock_s) begin
      lock_cnt_d = {LF_W{1'b0}};
    end else if (lock_cnt_q == LF_MAX) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + LF_ONE;
    end

    // The timer only advances while staying in a timed state, so every
    // state change leaves it at zero.
    case (state_q)
      ST_RESTART: begin
        if (timer_q == WAKE_LAST) begin
          state_d = ST_WAIT_READY;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      ST_WAIT_READY: begin
        if (!nrdy_s) begin
          state_d = ST_UP;
          retry_d = 2'd0;
        end else if (timer_q == READY_LAST) begin
          retry_d = retry_inc_s;
          if (retry_inc_s == MAX_RETRY_CNT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RESTART;
          end
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      ST_UP: begin
        // Lock loss outranks a simultaneous suspend request.
        if (lock_loss_s || nrdy_s) begin
          state_d    = ST_RESTART;
          drop_inc_s = 1'b1;
        end else if (susp_s) begin
          state_d = ST_SUSPEND;
        end else begin
          state_d = ST_UP;
        end
      end
      ST_SUSPEND: begin
        if (!susp_s) begin
          state_d = ST_RESTART;
        end else begin
          state_d = ST_SUSPEND;
        end
      end
      ST_FAULT: begin
        if (retry_req) begin
          state_d = ST_RESTART;
          retry_d = 2'd0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_RESTART;
        retry_d = 2'd0;
      end
    endcase

    init_rst_d = (state_d == ST_RESTART) || (state_d == ST_FAULT);
    wakeup_d   = (state_d == ST_WAIT_READY) || (state_d == ST_UP) ||
                 (state_d == ST_SUSPEND);
    link_up_d  = (state_d == ST_UP);
    fault_d    = (state_d == ST_FAULT);
  end

  // Synchronizers, FSM state, timers and registered outputs
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      lock_sync_q <= 2'b00;
      nrdy_sync_q <= 2'b00;
      susp_sync_q <= 2'b00;
      state_q     <= ST_RESTART;
      timer_q     <= 20'd0;
      retry_q     <= 2'd0;
      lock_cnt_q  <= {LF_W{1'b0}};
      init_rst_q  <= 1'b1;
      wakeup_q    <= 1'b0;
      link_up_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], usb_clk_lock};
      nrdy_sync_q <= {nrdy_sync_q[0], n_ready};
      susp_sync_q <= {susp_sync_q[0], suspend};
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_cnt_q  <= lock_cnt_d;
      init_rst_q  <= init_rst_d;
      wakeup_q    <= wakeup_d;
      link_up_q   <= link_up_d;
      fault_q     <= fault_d;
    end
  end

  assign init_rst  = init_rst_q;
  assign wakeup    = wakeup_q;
  assign link_up   = link_up_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

`ifdef USB_SUP_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of link drops (UP->RESTART only)
  always_comb begin
    if (drop_inc_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign link_drop_cnt = drop_cnt_q;
`else
  logic drop_unused_s;
  assign drop_unused_s = drop_inc_s;
  assign link_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_usb_link_supervisor.sv
// Self-checking bench for usb_link_supervisor with WAKE_PULSE_CYCLES=4,
// READY_TIMEOUT=100, MAX_RETRIES=3, LOCK_FILTER=8. Honours
// USB_SUP_DROP_CNT_EN for the expected link_drop_cnt values.
module tb_usb_link_supervisor;

  logic        clk = 1'b0;
  logic        rst_in, usb_clk_lock, n_ready, suspend, retry_req;
  logic        wakeup, init_rst, link_up, fault;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;
  logic [15:0] link_drop_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef USB_SUP_DROP_CNT_EN
  localparam logic [15:0] D1 = 16'd1, D2 = 16'd2, D3 = 16'd3;
`else
  localparam logic [15:0] D1 = 16'd0, D2 = 16'd0, D3 = 16'd0;
`endif

  typedef struct {
    logic        rst;
    logic        lock;
    logic        nrdy;
    logic        susp;
    int          n;
    logic [2:0]  st;
    logic        lu;
    logic        ir;
    logic        wk;
    logic        flt;
    logic [1:0]  rc;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl [0:17];

  usb_link_supervisor #(
    .WAKE_PULSE_CYCLES(4),
    .READY_TIMEOUT(100),
    .MAX_RETRIES(3),
    .LOCK_FILTER(8)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .usb_clk_lock(usb_clk_lock),
    .n_ready(n_ready),
    .suspend(suspend),
    .retry_req(retry_req),
    .wakeup(wakeup),
    .init_rst(init_rst),
    .link_up(link_up),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .state(state),
    .link_drop_cnt(link_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic lu,
                          input logic ir, input logic wk, input logic flt,
                          input logic [1:0] rc);
    chk({tag, "_state"},     {29'd0, state},     {29'd0, st});
    chk({tag, "_link_up"},   {31'd0, link_up},   {31'd0, lu});
    chk({tag, "_init_rst"},  {31'd0, init_rst},  {31'd0, ir});
    chk({tag, "_wakeup"},    {31'd0, wakeup},    {31'd0, wk});
    chk({tag, "_fault"},     {31'd0, fault},     {31'd0, flt});
    chk({tag, "_retry_cnt"}, {30'd0, retry_cnt}, {30'd0, rc});
  endtask

  // Bounded wait for a state, sampled on falling edges
  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (state == tgt) hit = 1'b1;
    end
    chk(name, {31'd0, hit}, 32'd1);
  endtask

  // Main stimulus: vector table, then hand-written corner sequences
  initial begin
    //            rst   lock  nrdy  susp  n  st    lu    ir    wk    flt   rc    drop
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, D1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, D1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, D1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, D1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, D1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, D1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, D1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, D1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, D1};

    rst_in       = 1'b1;
    usb_clk_lock = 1'b1;
    n_ready      = 1'b1;
    suspend      = 1'b0;
    retry_req    = 1'b0;
    @(negedge clk);

    // Bring-up, lock filter, suspend/resume
    for (int i = 0; i < 18; i++) begin
      rst_in       = tbl[i].rst;
      usb_clk_lock = tbl[i].lock;
      n_ready      = tbl[i].nrdy;
      suspend      = tbl[i].susp;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      chk_outs($sformatf("v%0d", i), tbl[i].st, tbl[i].lu, tbl[i].ir,
               tbl[i].wk, tbl[i].flt, tbl[i].rc);
      chk($sformatf("v%0d_drop", i), {16'd0, link_drop_cnt}, {16'd0, tbl[i].drop});
    end

    // Lock loss declared in the same cycle suspend is seen: RESTART wins
    usb_clk_lock = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    suspend = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("tie_pre_state", {29'd0, state}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk_outs("tie", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("tie_drop", {16'd0, link_drop_cnt}, {16'd0, D2});
    suspend      = 1'b0;
    usb_clk_lock = 1'b1;
    wait_state(3'd2, 20, "tie_reup");

    // n_ready lost while up, then three timeout rounds into FAULT
    n_ready = 1'b1;
    wait_state(3'd0, 10, "nrdy_drop");
    chk("nrdy_drop_cnt", {16'd0, link_drop_cnt}, {16'd0, D3});
    repeat (103) @(posedge clk);
    @(negedge clk);
    chk_outs("r1_pre", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    chk_outs("r1", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    retry_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    retry_req = 1'b0;
    chk_outs("ign_retry", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    repeat (102) @(posedge clk);
    @(negedge clk);
    chk_outs("r2_pre", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    @(posedge clk);
    @(negedge clk);
    chk_outs("r2", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    repeat (103) @(posedge clk);
    @(negedge clk);
    chk_outs("r3_pre", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    @(posedge clk);
    @(negedge clk);
    chk_outs("r3_fault", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_outs("fault_hold", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    retry_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    retry_req = 1'b0;
    chk_outs("retry", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Async reset mid WAIT_READY (timer=50), then a full restart from zero
    repeat (104) @(posedge clk);
    @(negedge clk);
    chk_outs("c_r1", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("c_wait", {29'd0, state}, 32'd1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_in = 1'b1;
    #1;
    chk_outs("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("async_rst_drop", {16'd0, link_drop_cnt}, 32'd0);
    @(negedge clk);
    rst_in = 1'b0;
    repeat (103) @(posedge clk);
    @(negedge clk);
    chk_outs("post_rst_pre", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    chk_outs("post_rst_to", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_link_supervisor.md
USB_LINK_SUPERVISOR -- requirements
Module: usb_link_supervisor

Interface
REQ-001 Parameters SHALL be:
- WAKE_PULSE_CYCLES, 16: cycles init_rst is held high and wakeup low per restart.
- READY_TIMEOUT, 1048576: cycles allowed in WAIT_READY before a retry.
- MAX_RETRIES, 3: consecutive timeouts before FAULT (range 1..3).
- LOCK_FILTER, 8: consecutive synchronized-low lock samples that count as lock loss.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- usb_clk_lock  in  1  USB clock PLL lock; asynchronous.
- n_ready  in  1  active-low ready from the USB init stage; asynchronous.
- suspend  in  1  host suspend request; asynchronous.
- retry_req  in  1  single-cycle pulse, synchronous to clk; clears FAULT.
- wakeup  out  1  drives the init stage wakeup input; low restarts its clock-reset sequence.
- init_rst  out  1  drives the init stage rst input.
- link_up  out  1  link usable.
- fault  out  1  retries exhausted.
- retry_cnt  out  2  consecutive timeout count.
- state  out  3  current state encoding.
- link_drop_cnt  out  16  UP-exit count (see Configuration).

Function
REQ-003 usb_clk_lock, n_ready and suspend SHALL each pass through a 2-flop synchronizer; all decisions SHALL use the synchronized values (lock_s, nrdy_s, susp_s).
REQ-004 The state encoding SHALL be RESTART=0, WAIT_READY=1, UP=2, SUSPEND=3, FAULT=4; all outputs SHALL be registered.
REQ-005 RESTART SHALL drive init_rst=1, wakeup=0 and link_up=0 for exactly WAKE_PULSE_CYCLES cycles, then go to WAIT_READY.
REQ-006 WAIT_READY SHALL drive init_rst=0 and wakeup=1, and SHALL run a timer from 0.
REQ-007 In WAIT_READY, nrdy_s=0 SHALL cause a transition to UP and clear retry_cnt.
REQ-008 In WAIT_READY, if the timer reaches READY_TIMEOUT-1 with nrdy_s=1, retry_cnt SHALL increment; the block SHALL go to FAULT if the new value equals MAX_RETRIES, else to RESTART.
REQ-009 UP SHALL drive link_up=1 and wakeup=1.
REQ-010 A lock-loss counter SHALL count consecutive lock_s=0 cycles and clear on lock_s=1; it SHALL reach LOCK_FILTER before lock loss is declared.
REQ-011 In UP, declared lock loss or nrdy_s=1 SHALL cause a transition to RESTART, with link_up low on the next cycle.
REQ-012 In UP, susp_s=1 SHALL cause a transition to SUSPEND.
REQ-013 If lock loss and susp_s=1 occur in the same cycle in UP, lock loss SHALL win and the block SHALL go to RESTART.
REQ-014 SUSPEND SHALL drive link_up=0, wakeup=1 and init_rst=0; susp_s=0 SHALL cause a transition to RESTART.
REQ-015 FAULT SHALL drive fault=1, init_rst=1 and wakeup=0; retry_req=1 SHALL clear retry_cnt and fault and cause a transition to RESTART.
REQ-016 retry_req SHALL be ignored in all states other than FAULT.
REQ-017 The WAIT_READY timer SHALL be 20 bits wide and SHALL clear on every state entry.

Reset
REQ-018 rst_in=1 SHALL immediately force:
- state=RESTART, init_rst=1, wakeup=0;
- link_up=0, fault=0;
- retry_cnt=0, link_drop_cnt=0;
- all timers and synchronizer flops to 0.
REQ-019 After rst_in deasserts, a full WAKE_PULSE_CYCLES RESTART SHALL run; assertion of rst_in mid-operation SHALL abort any state.

Configuration
REQ-020 With USB_SUP_DROP_CNT_EN defined, link_drop_cnt SHALL increment, saturating at 16'hFFFF, on each UP->RESTART transition; it SHALL NOT increment on UP->SUSPEND.
REQ-021 Without USB_SUP_DROP_CNT_EN, link_drop_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
Parameters for all scenarios: WAKE_PULSE_CYCLES=4, READY_TIMEOUT=100, MAX_RETRIES=3, LOCK_FILTER=8.
REQ-022 Release reset with lock=1, then n_ready low 10 cycles later -> init_rst high exactly 4 cycles, then link_up=1 within 3 cycles of n_ready falling, retry_cnt=0.
REQ-023 Hold n_ready=1 -> three RESTART/WAIT_READY rounds of 104 cycles each, retry_cnt reaching 1, 2, 3, then fault=1, state=4; a retry_req pulse -> state=0, fault=0, retry_cnt=0.
REQ-024 In UP, drop lock 7 cycles then restore -> link_up stays 1; drop lock 10 cycles -> state=RESTART and link_drop_cnt=1 when USB_SUP_DROP_CNT_EN is defined.
REQ-025 In UP, assert suspend and drop lock in the same cycle -> state=RESTART, not SUSPEND.
REQ-026 In UP, assert suspend -> state=3, link_up=0; deassert -> RESTART with 4 cycles of init_rst, and link_drop_cnt unchanged.
REQ-027 Pulse rst_in during WAIT_READY with timer=50 -> outputs take their reset values asynchronously, and the timer restarts from 0.
